// File: rtl/sigdel_pkg.sv
// Shared types and constants for the sigma-delta sample sequencer.
package sigdel_pkg;

  // Default sample width; matches the modulator input.
  localparam int DEF_DATA_W = 8;

  // Code that drives the modulator to zero output.
  localparam logic [DEF_DATA_W-1:0] MIDSCALE = DEF_DATA_W'(1) << (DEF_DATA_W - 1);

  // Sequencer states. RAMP is only reachable when SIGDEL_SEQ_RAMP_EN is defined.
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    PRIME    = 3'd1,
    RUN      = 3'd2,
    UNDERRUN = 3'd3,
    RAMP     = 3'd4
  } state_t;

  // States in which the update divider counts and running is reported.
  function automatic logic is_active(input state_t s);
    return (s == RUN) || (s == UNDERRUN) || (s == RAMP);
  endfunction

endpackage

// File: rtl/sigdel_fifo.sv
// Small synchronous FIFO holding host samples for the sequencer.
// Push is ignored when full, pop is ignored when empty, flush empties it.
// No bypass: a sample pushed this cycle is visible on head next cycle.
module sigdel_fifo
#(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        head,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW    = $clog2(DEPTH);
  localparam int LVL_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [LVL_W-1:0]  count;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == LVL_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign level   = count;

  // Storage write; contents need no reset because count gates visibility.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers and occupancy; reset and flush both empty the FIFO.
  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/sigdel_seq.sv
// Sample sequencer for the sigma-delta modulator input.
// Host bytes are queued in a FIFO; a divider-paced FSM pops one sample per
// tick and holds it on sample_out. Stopping returns the output to midscale,
// either in one step or, with SIGDEL_SEQ_RAMP_EN defined, one LSB per tick.
//
// Handshake: a sample transfers on every rising clk edge where wr_valid and
// wr_ready are both high. wr_ready depends only on FIFO occupancy, never on
// wr_valid; the host must hold wr_data stable while wr_valid is high and
// wr_ready is low.
module sigdel_seq
  import sigdel_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int DEPTH     = 8,
  parameter int DIV_W     = 16,
  parameter int PRIME_LVL = 4
)
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic [DIV_W-1:0]       cfg_div,
  input  logic                   wr_valid,
  input  logic [DATA_W-1:0]      wr_data,
  output logic                   wr_ready,
  output logic [DATA_W-1:0]      sample_out,
  output logic                   sample_stb,
  output logic                   underrun,
  input  logic                   underrun_clr,
  output logic [$clog2(DEPTH):0] level,
  output logic                   running,
  output state_t                 fsm_state
);

  localparam int LVL_W = $clog2(DEPTH) + 1;
  localparam logic [DATA_W-1:0] MID     = DATA_W'(1) << (DATA_W - 1);
  localparam logic [LVL_W-1:0]  PRIME_Q = LVL_W'(PRIME_LVL);

  state_t            state_q, state_d;
  logic [DIV_W-1:0]  cnt_q;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              stb_q, stb_d;
  logic              underrun_q;
  logic              urun_set;
  logic              counting;
  logic              tick;
  logic              pop;
  logic              flush;
  logic              fifo_full;
  logic              fifo_empty;
  logic [DATA_W-1:0] fifo_head;

  sigdel_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (wr_valid && wr_ready),
    .pop   (pop),
    .flush (flush),
    .din   (wr_data),
    .head  (fifo_head),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Comparing with >= means a cfg_div lowered below cnt ticks at once.
  assign counting = is_active(state_q);
  assign tick     = counting && (cnt_q >= cfg_div);

  // Update-period divider: free-running while active, parked at zero otherwise.
  always_ff @(posedge clk) begin
    if (rst || !counting || tick) cnt_q <= '0;
    else                          cnt_q <= cnt_q + DIV_W'(1);
  end

  // Next-state, FIFO control and next output code.
  always_comb begin
    state_d  = state_q;
    sample_d = sample_q;
    stb_d    = 1'b0;
    pop      = 1'b0;
    flush    = 1'b0;
    urun_set = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) state_d = PRIME;
      end
      PRIME: begin
        if (!enable) begin
          state_d  = IDLE;
          flush    = 1'b1;
          sample_d = MID;
        end else if (level >= PRIME_Q) begin
          state_d = RUN;
        end
      end
      RUN, UNDERRUN: begin
        if (!enable) begin
          flush = 1'b1;
`ifdef SIGDEL_SEQ_RAMP_EN
          state_d = RAMP;
`else
          state_d  = IDLE;
          sample_d = MID;
`endif
        end else if (tick) begin
          if (!fifo_empty) begin
            pop      = 1'b1;
            sample_d = fifo_head;
            stb_d    = 1'b1;
            state_d  = RUN;
          end else begin
            urun_set = 1'b1;
            state_d  = UNDERRUN;
          end
        end
      end
      RAMP: begin
`ifdef SIGDEL_SEQ_RAMP_EN
        if (enable) begin
          state_d = PRIME;
        end else if (sample_q == MID) begin
          state_d = IDLE;
        end else if (tick) begin
          sample_d = (sample_q > MID) ? sample_q - DATA_W'(1) : sample_q + DATA_W'(1);
        end
`else
        state_d  = IDLE;
        sample_d = MID;
`endif
      end
      default: begin
        state_d  = IDLE;
        flush    = 1'b1;
        sample_d = MID;
      end
    endcase
  end

  // State, output register and sticky underrun flag (set beats clear).
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sample_q   <= MID;
      stb_q      <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sample_q <= sample_d;
      stb_q    <= stb_d;
      if (urun_set)          underrun_q <= 1'b1;
      else if (underrun_clr) underrun_q <= 1'b0;
    end
  end

  assign wr_ready   = !fifo_full;
  assign sample_out = sample_q;
  assign sample_stb = stb_q;
  assign underrun   = underrun_q;
  assign running    = counting;
  assign fsm_state  = state_q;

endmodule

// File: tb/tb_sigdel_seq.sv
// Self-checking bench for sigdel_seq (default parameters).
// Expected samples are queued when the host handshake completes and are
// compared when sample_stb fires; fill-level behaviour is table-driven.
module tb_sigdel_seq;
  import sigdel_pkg::*;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 8;
  localparam int DIV_W  = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              enable;
  logic [DIV_W-1:0]  cfg_div;
  logic              wr_valid;
  logic [DATA_W-1:0] wr_data;
  logic              wr_ready;
  logic [DATA_W-1:0] sample_out;
  logic              sample_stb;
  logic              underrun;
  logic              underrun_clr;
  logic [3:0]        level;
  logic              running;
  state_t            fsm_state;

  logic [DATA_W-1:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [7:0] data;
    logic [3:0] lvl;
    logic       rdy;
  } vec_t;
  vec_t vecs[9];

  sigdel_seq dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .cfg_div      (cfg_div),
    .wr_valid     (wr_valid),
    .wr_data      (wr_data),
    .wr_ready     (wr_ready),
    .sample_out   (sample_out),
    .sample_stb   (sample_stb),
    .underrun     (underrun),
    .underrun_clr (underrun_clr),
    .level        (level),
    .running      (running),
    .fsm_state    (fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock: log accepted writes, advance, then score any strobe.
  task automatic step();
    logic [DATA_W-1:0] e;
    if (wr_valid && wr_ready) exp_q.push_back(wr_data);
    @(posedge clk);
    #1;
    if (sample_stb) begin
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL stb_spurious: strobe with sample_out %0h and no expected sample", sample_out);
      end else begin
        e = exp_q.pop_front();
        n_fail += (sample_out !== e) ? 1 : 0;
        if (sample_out !== e)
          $display("FAIL sample: got %0h expected %0h", sample_out, e);
      end
    end
  endtask

  task automatic write_sample(input logic [7:0] d);
    wr_valid = 1'b1;
    wr_data  = d;
    step();
    wr_valid = 1'b0;
  endtask

  // Step until sample_stb; n returns cycles taken.
  task automatic wait_stb(input int budget, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!sample_stb && n < budget);
    if (!sample_stb) begin
      n_tests++;
      n_fail++;
      $display("FAIL stb_timeout: no strobe within %0d cycles", budget);
    end
  endtask

  initial begin
    int n;
    logic [7:0] rv;

    for (int i = 0; i < 9; i++) begin
      vecs[i].data = 8'h80 + 8'(i);
      vecs[i].lvl  = (i < 8) ? 4'(i + 1) : 4'd8;
      vecs[i].rdy  = (i + 1) < 8;
    end

    rst = 1'b1; enable = 1'b0; cfg_div = 16'd3;
    wr_valid = 1'b0; wr_data = '0; underrun_clr = 1'b0;
    repeat (3) step();
    rst = 1'b0;

    // Reset then idle
    for (int i = 0; i < 20; i++) begin
      step();
      check("idle", {20'd0, sample_out, wr_ready, level[2:0], running},
            {20'd0, 8'h80, 1'b1, 3'd0, 1'b0});
    end
    check("idle_level", 32'(level), 32'd0);
    check("idle_state", 32'(fsm_state), 32'(IDLE));

    // Prime and run
    write_sample(8'd10);
    write_sample(8'd20);
    write_sample(8'd30);
    write_sample(8'd40);
    check("prime_level", 32'(level), 32'd4);
    enable = 1'b1;
    step();
    check("prime_state", 32'(fsm_state), 32'(PRIME));
    step();
    check("run_state", 32'(fsm_state), 32'(RUN));
    check("run_running", 32'(running), 32'd1);
    for (int i = 0; i < 4; i++) begin
      wait_stb(20, n);
      check("stb_spacing", 32'(n), 32'(cfg_div) + 32'd1);
    end
    check("run_sample_40", 32'(sample_out), 32'd40);

    // Underrun
    n = 0;
    do begin step(); n++; end while (!underrun && n < 20);
    check("urun_delay", 32'(n), 32'd4);
    check("urun_state", 32'(fsm_state), 32'(UNDERRUN));
    check("urun_hold", 32'(sample_out), 32'd40);
    write_sample(8'd50);
    wait_stb(20, n);
    check("urun_recover_delay", 32'(n + 1), 32'd4);
    check("urun_recover_state", 32'(fsm_state), 32'(RUN));
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("urun_clear", 32'(underrun), 32'd0);
    step();
    step();
    underrun_clr = 1'b1;
    step();
    underrun_clr = 1'b0;
    check("urun_set_beats_clr", 32'(underrun), 32'd1);
    check("urun_again_state", 32'(fsm_state), 32'(UNDERRUN));

    enable = 1'b0;
    step();
    exp_q.delete();
    check("stop_state", 32'(fsm_state), 32'(IDLE));
    check("stop_mid", 32'(sample_out), 32'h80);
    check("stop_level", 32'(level), 32'd0);

    // Full FIFO, table-driven
    for (int i = 0; i < 9; i++) begin
      write_sample(vecs[i].data);
      check("fill_level", 32'(level), 32'(vecs[i].lvl));
      check("fill_ready", 32'(wr_ready), 32'(vecs[i].rdy));
    end

    // Stop mid-run with level 3
    enable = 1'b1;
    step();
    step();
    check("run2_state", 32'(fsm_state), 32'(RUN));
    for (int i = 0; i < 5; i++) wait_stb(20, n);
    check("run2_level", 32'(level), 32'd3);
    check("run2_sample", 32'(sample_out), 32'h84);
    enable = 1'b0;
    step();
    exp_q.delete();
    check("stop2_level", 32'(level), 32'd0);
`ifdef SIGDEL_SEQ_RAMP_EN
    check("ramp_state", 32'(fsm_state), 32'(RAMP));
    check("ramp_hold", 32'(sample_out), 32'h84);
    check("ramp_running", 32'(running), 32'd1);
    for (int v = 8'h83; v >= 8'h80; v--) begin
      n = 0;
      do begin step(); n++; end while (sample_out != 8'(v) && n < 20);
      check("ramp_step", 32'(sample_out), 32'(v));
    end
    step();
    check("ramp_done_state", 32'(fsm_state), 32'(IDLE));
`else
    check("stop2_state", 32'(fsm_state), 32'(IDLE));
    check("stop2_mid", 32'(sample_out), 32'h80);
`endif
    check("stop2_running", 32'(running), 32'd0);

    // cfg_div = 0 then rst mid-run
    cfg_div = 16'd0;
    for (int i = 0; i < 6; i++) begin
      rv = 8'($urandom_range(0, 255));
      write_sample(rv);
    end
    enable = 1'b1;
    step();
    step();
    check("fast_state", 32'(fsm_state), 32'(RUN));
    for (int i = 0; i < 3; i++) begin
      wait_stb(5, n);
      check("fast_spacing", 32'(n), 32'd1);
    end
    check("fast_level", 32'(level), 32'd3);
    rst = 1'b1;
    step();
    exp_q.delete();
    check("rst_state", 32'(fsm_state), 32'(IDLE));
    check("rst_regs", {24'd0, sample_stb, underrun, running, wr_ready, level},
          {24'd0, 1'b0, 1'b0, 1'b0, 1'b1, 4'd0});
    check("rst_mid", 32'(sample_out), 32'h80);
    rst = 1'b0;
    enable = 1'b0;
    step();
    check("post_rst_state", 32'(fsm_state), 32'(IDLE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
